// File: rtl/div_scheduler.sv
// ---------------------------------------------------------------------------
// div_scheduler
//
// Shares one fixed-latency pipelined unsigned divider among NUM_REQ
// requesters. Requests are arbitrated round-robin, at most one operation is
// issued per cycle, and every in-flight operation is tracked by a tag
// pipeline so its quotient goes back to the requester that issued it.
// Divide-by-zero is intercepted: the divider sees a divisor of 1 and the
// response carries an all-ones quotient with resp_dz set.
//
// Ports
//   clk, rst       clock; asynchronous active-high reset
//   req_valid      per-requester request valid
//   req_ready      per-requester one-hot grant (handshake = valid & ready)
//   req_dividend   flattened dividends, requester i uses slice i
//   req_divisor    flattened divisors, requester i uses slice i
//   div_start      issue strobe to the divider
//   div_dividend   dividend to the divider
//   div_divisor    divisor to the divider
//   div_quotient   divider result, valid LAT cycles after the divider
//                  registers div_start
//   resp_valid     one-cycle response pulse to requester i
//   resp_quotient  quotient for the current response (shared bus)
//   resp_dz        current response was a divide-by-zero
//   in_flight      number of outstanding operations
// ---------------------------------------------------------------------------
module div_scheduler #(
  parameter int WIDTH   = 16,
  parameter int NUM_REQ = 3,
  parameter int LAT     = 17
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*WIDTH-1:0]      req_dividend,
  input  logic [NUM_REQ*WIDTH-1:0]      req_divisor,
  output logic                          div_start,
  output logic [WIDTH-1:0]              div_dividend,
  output logic [WIDTH-1:0]              div_divisor,
  input  logic [WIDTH-1:0]              div_quotient,
  output logic [NUM_REQ-1:0]            resp_valid,
  output logic [WIDTH-1:0]              resp_quotient,
  output logic                          resp_dz,
  output logic [$clog2(NUM_REQ+1)-1:0]  in_flight
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int SUM_W = IDX_W + 1;
  localparam int CNT_W = $clog2(NUM_REQ + 1);
  // Tag stage 0 sits alongside div_start; the divider registers div_start at
  // the following edge and its quotient is valid LAT cycles after that, so
  // the tag in the last stage lines up with div_quotient.
  localparam int DEPTH = LAT + 2;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);

  // Arbitration state and combinational grant
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [NUM_REQ-1:0] pend_q, pend_d;
  logic [NUM_REQ-1:0] cand;
  logic [NUM_REQ-1:0] grant;
  logic [IDX_W-1:0]   grant_idx;
  logic               grant_found;
  logic [SUM_W-1:0]   scan_idx;
  logic               hs;

  // Operands of the granted requester
  logic [WIDTH-1:0]   sel_dividend;
  logic [WIDTH-1:0]   sel_divisor;
  logic               sel_dz;

  // Issue registers
  logic               div_start_q, div_start_d;
  logic [WIDTH-1:0]   div_dividend_q, div_dividend_d;
  logic [WIDTH-1:0]   div_divisor_q, div_divisor_d;

  // Tag pipeline
  logic               tag_valid_q [DEPTH];
  logic               tag_valid_d [DEPTH];
  logic [IDX_W-1:0]   tag_idx_q   [DEPTH];
  logic [IDX_W-1:0]   tag_idx_d   [DEPTH];
  logic               tag_dz_q    [DEPTH];
  logic               tag_dz_d    [DEPTH];

  // Response and occupancy registers
  logic [NUM_REQ-1:0] resp_valid_q, resp_valid_d;
  logic [WIDTH-1:0]   resp_quotient_q, resp_quotient_d;
  logic               resp_dz_q, resp_dz_d;
  logic [CNT_W-1:0]   in_flight_q, in_flight_d;

  // Round-robin search: starting at the pointer and wrapping, the first
  // requester that is valid and has nothing outstanding wins. The grant is
  // forced low while reset is held so req_ready also resets asynchronously.
  always_comb begin
    cand        = req_valid & ~pend_q;
    grant       = '0;
    grant_idx   = '0;
    grant_found = 1'b0;
    scan_idx    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan_idx = {1'b0, rr_ptr_q} + SUM_W'(k);
      if (scan_idx >= SUM_W'(NUM_REQ)) begin
        scan_idx = scan_idx - SUM_W'(NUM_REQ);
      end
      if (!grant_found && cand[scan_idx[IDX_W-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = scan_idx[IDX_W-1:0];
      end
    end
    if (grant_found && !rst) begin
      grant[grant_idx] = 1'b1;
    end
  end

  assign req_ready = grant;
  assign hs        = |grant;

  // Pick the granted requester's operand slices out of the flattened buses.
  always_comb begin
    sel_dividend = '0;
    sel_divisor  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_idx == IDX_W'(i)) begin
        sel_dividend = req_dividend[i*WIDTH +: WIDTH];
        sel_divisor  = req_divisor[i*WIDTH +: WIDTH];
      end
    end
    sel_dz = (sel_divisor == '0);
  end

  // Pointer, outstanding flags, issue registers and occupancy count.
  // An outstanding flag is cleared by the response pulse itself, so a
  // requester cannot be re-granted during the cycle its pulse is visible.
  always_comb begin
    rr_ptr_d       = rr_ptr_q;
    pend_d         = pend_q & ~resp_valid_q;
    div_start_d    = hs;
    div_dividend_d = div_dividend_q;
    div_divisor_d  = div_divisor_q;
    in_flight_d    = in_flight_q;
    if (hs) begin
      rr_ptr_d       = (grant_idx == LAST_IDX) ? '0 : grant_idx + IDX_W'(1);
      pend_d         = pend_d | grant;
      div_dividend_d = sel_dividend;
      div_divisor_d  = sel_dz ? WIDTH'(1) : sel_divisor;
    end
    if (hs && !(|resp_valid_q)) begin
      in_flight_d = in_flight_q + CNT_W'(1);
    end else if (!hs && (|resp_valid_q)) begin
      in_flight_d = in_flight_q - CNT_W'(1);
    end
  end

  // The tag pipeline shifts every cycle, bubbles included, so each tag keeps
  // a fixed distance from the divider result it belongs to.
  always_comb begin
    tag_valid_d[0] = hs;
    tag_idx_d[0]   = grant_idx;
    tag_dz_d[0]    = hs & sel_dz;
    for (int k = 1; k < DEPTH; k++) begin
      tag_valid_d[k] = tag_valid_q[k-1];
      tag_idx_d[k]   = tag_idx_q[k-1];
      tag_dz_d[k]    = tag_dz_q[k-1];
    end
  end

  // A valid tag leaving the pipeline becomes a response pulse; a
  // divide-by-zero tag replaces the divider output with all ones.
  always_comb begin
    resp_valid_d    = '0;
    resp_quotient_d = resp_quotient_q;
    resp_dz_d       = resp_dz_q;
    if (tag_valid_q[DEPTH-1]) begin
      resp_valid_d[tag_idx_q[DEPTH-1]] = 1'b1;
      resp_quotient_d = tag_dz_q[DEPTH-1] ? '1 : div_quotient;
      resp_dz_d       = tag_dz_q[DEPTH-1];
    end
  end

  // State registers. Reset discards every in-flight tag, so divider output
  // that arrives after reset is released is never turned into a response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_q        <= '0;
      pend_q          <= '0;
      div_start_q     <= 1'b0;
      div_dividend_q  <= '0;
      div_divisor_q   <= '0;
      resp_valid_q    <= '0;
      resp_quotient_q <= '0;
      resp_dz_q       <= 1'b0;
      in_flight_q     <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        tag_valid_q[k] <= 1'b0;
        tag_idx_q[k]   <= '0;
        tag_dz_q[k]    <= 1'b0;
      end
    end else begin
      rr_ptr_q        <= rr_ptr_d;
      pend_q          <= pend_d;
      div_start_q     <= div_start_d;
      div_dividend_q  <= div_dividend_d;
      div_divisor_q   <= div_divisor_d;
      resp_valid_q    <= resp_valid_d;
      resp_quotient_q <= resp_quotient_d;
      resp_dz_q       <= resp_dz_d;
      in_flight_q     <= in_flight_d;
      for (int k = 0; k < DEPTH; k++) begin
        tag_valid_q[k] <= tag_valid_d[k];
        tag_idx_q[k]   <= tag_idx_d[k];
        tag_dz_q[k]    <= tag_dz_d[k];
      end
    end
  end

  assign div_start     = div_start_q;
  assign div_dividend  = div_dividend_q;
  assign div_divisor   = div_divisor_q;
  assign resp_valid    = resp_valid_q;
  assign resp_quotient = resp_quotient_q;
  assign resp_dz       = resp_dz_q;
  assign in_flight     = in_flight_q;

endmodule

// File: tb/tb_div_scheduler.sv
// ---------------------------------------------------------------------------
// tb_div_scheduler
//
// Directed bench for div_scheduler with a behavioural pipelined divider.
// Every handshake pushes the expected response (requester, quotient, dz flag
// and arrival cycle) into a scoreboard queue; every response pulse pops and
// compares it. The directed steps add explicit checks of grants, issue
// operands, occupancy and reset behaviour.
// ---------------------------------------------------------------------------
module tb_div_scheduler;

  localparam int W     = 16;
  localparam int NR    = 3;
  localparam int LAT   = 17;
  localparam int CNT_W = $clog2(NR + 1);

  logic              clk;
  logic              rst;
  logic [NR-1:0]     req_valid;
  logic [NR-1:0]     req_ready;
  logic [NR*W-1:0]   req_dividend;
  logic [NR*W-1:0]   req_divisor;
  logic              div_start;
  logic [W-1:0]      div_dividend;
  logic [W-1:0]      div_divisor;
  logic [W-1:0]      div_quotient;
  logic [NR-1:0]     resp_valid;
  logic [W-1:0]      resp_quotient;
  logic              resp_dz;
  logic [CNT_W-1:0]  in_flight;

  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;

  typedef struct {
    int         idx;
    logic [W-1:0] q;
    logic       dz;
    int         due;
  } exp_t;

  exp_t sb[$];
  exp_t monE;

  div_scheduler #(.WIDTH(W), .NUM_REQ(NR), .LAT(LAT)) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_dividend  (req_dividend),
    .req_divisor   (req_divisor),
    .div_start     (div_start),
    .div_dividend  (div_dividend),
    .div_divisor   (div_divisor),
    .div_quotient  (div_quotient),
    .resp_valid    (resp_valid),
    .resp_quotient (resp_quotient),
    .resp_dz       (resp_dz),
    .in_flight     (in_flight)
  );

  // 10 ns clock; the design works on rising edges.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle counter: value N at a falling edge means N rising edges so far.
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural divider: registers div_start and operands at a rising edge
  // and presents the quotient LAT cycles later. It is not reset, so stale
  // results still arrive after a reset. Idle slots show a marker value.
  logic [W-1:0] divQ [0:LAT];
  logic         divV [0:LAT];

  always @(posedge clk) begin
    divV[0] <= div_start;
    divQ[0] <= (div_start === 1'b1 && div_divisor != 0) ? div_dividend / div_divisor : 16'hDEAD;
    for (int k = 1; k <= LAT; k++) begin
      divV[k] <= divV[k-1];
      divQ[k] <= divQ[k-1];
    end
  end

  assign div_quotient = (divV[LAT] === 1'b1) ? divQ[LAT] : 16'hDEAD;

  // Scoreboard monitor on the falling edge: compare responses against the
  // queue, flag late ones, check the grant is one-hot, check a zero divisor
  // never reaches the divider, and push an entry for the handshake that the
  // coming rising edge will complete.
  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
    end else begin
      if (resp_valid !== '0) begin
        compared++;
        if (sb.size() == 0) begin
          assert (resp_valid === '0) else begin
            mismatched++;
            $error("[TB] FAIL sb_unexpected: observed resp_valid=%b expected no response", resp_valid);
          end
        end else begin
          monE = sb.pop_front();
          assert (resp_valid === (NR'(1) << monE.idx) && resp_quotient === monE.q &&
                  resp_dz === monE.dz && cyc == monE.due) else begin
            mismatched++;
            $error("[TB] FAIL sb_resp: observed valid=%b q=%0h dz=%0b cyc=%0d expected valid=%b q=%0h dz=%0b cyc=%0d",
                   resp_valid, resp_quotient, resp_dz, cyc, NR'(1) << monE.idx, monE.q, monE.dz, monE.due);
          end
        end
      end else if (sb.size() != 0) begin
        compared++;
        assert (cyc < sb[0].due) else begin
          mismatched++;
          $error("[TB] FAIL sb_missing: observed no response at cyc=%0d expected requester %0d at cyc=%0d",
                 cyc, sb[0].idx, sb[0].due);
          void'(sb.pop_front());
        end
      end

      if (div_start === 1'b1) begin
        compared++;
        assert (div_divisor !== '0) else begin
          mismatched++;
          $error("[TB] FAIL dz_leak: observed div_divisor=%0h expected nonzero", div_divisor);
        end
      end

      if ((req_valid & req_ready) !== '0) begin
        compared++;
        assert ($onehot(req_valid & req_ready)) else begin
          mismatched++;
          $error("[TB] FAIL grant_onehot: observed %b expected one-hot", req_valid & req_ready);
        end
        for (int i = 0; i < NR; i++) begin
          if (req_valid[i] && req_ready[i]) begin
            exp_t e;
            e.idx = i;
            e.dz  = (req_divisor[i*W +: W] == 0);
            e.q   = e.dz ? 16'hFFFF : req_dividend[i*W +: W] / req_divisor[i*W +: W];
            e.due = cyc + 1 + LAT + 2;
            sb.push_back(e);
          end
        end
      end
    end
  end

  // Drive one requester's valid and operands.
  task automatic applyStimulus(input int idx, input logic v, input logic [W-1:0] a, input logic [W-1:0] b);
    req_valid[idx]           = v;
    req_dividend[idx*W +: W] = a;
    req_divisor[idx*W +: W]  = b;
  endtask

  // One comparison point.
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // A lone request from one requester, checked from grant to response.
  task automatic runSingle(input string tag, input int idx, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [W-1:0] expQ, input logic expDz);
    logic [NR-1:0] oh;
    oh = NR'(1) << idx;
    @(posedge clk); #1;
    applyStimulus(idx, 1'b1, a, b);
    @(negedge clk);
    checkOutput({tag, "_ready"}, 32'(req_ready), 32'(oh));
    @(posedge clk); #1;
    applyStimulus(idx, 1'b0, a, b);
    @(negedge clk);
    checkOutput({tag, "_start"}, 32'(div_start), 32'd1);
    checkOutput({tag, "_dividend"}, 32'(div_dividend), 32'(a));
    checkOutput({tag, "_divisor"}, 32'(div_divisor), (b == 0) ? 32'd1 : 32'(b));
    checkOutput({tag, "_inflight1"}, 32'(in_flight), 32'd1);
    repeat (LAT + 2) @(negedge clk);
    checkOutput({tag, "_resp_valid"}, 32'(resp_valid), 32'(oh));
    checkOutput({tag, "_resp_q"}, 32'(resp_quotient), 32'(expQ));
    checkOutput({tag, "_resp_dz"}, 32'(resp_dz), 32'(expDz));
    @(negedge clk);
    checkOutput({tag, "_resp_done"}, 32'(resp_valid), 32'd0);
    checkOutput({tag, "_inflight0"}, 32'(in_flight), 32'd0);
  endtask

  // Global time limit so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation did not finish within time limit");
    $fatal(1, "[TB] timeout");
  end

  // Directed sequence of steps.
  initial begin
    logic anyHit;
    rst          = 1'b1;
    req_valid    = '0;
    req_dividend = '0;
    req_divisor  = '0;

    // Reset state, with all requesters asking so the gated grant is visible.
    req_valid = '1;
    repeat (3) @(negedge clk);
    checkOutput("rst_ready", 32'(req_ready), 32'd0);
    checkOutput("rst_start", 32'(div_start), 32'd0);
    checkOutput("rst_dividend", 32'(div_dividend), 32'd0);
    checkOutput("rst_divisor", 32'(div_divisor), 32'd0);
    checkOutput("rst_resp_valid", 32'(resp_valid), 32'd0);
    checkOutput("rst_resp_q", 32'(resp_quotient), 32'd0);
    checkOutput("rst_resp_dz", 32'(resp_dz), 32'd0);
    checkOutput("rst_inflight", 32'(in_flight), 32'd0);
    @(posedge clk); #1;
    req_valid = '0;
    rst       = 1'b0;

    // Single request and divide-by-zero.
    runSingle("single", 0, 16'd100, 16'd7, 16'd14, 1'b0);
    runSingle("dz", 1, 16'd55, 16'd0, 16'hFFFF, 1'b1);

    // Round robin from a fresh reset: grants 0,1,2 then nothing until the
    // responses, which come back in order on consecutive cycles.
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    applyStimulus(0, 1'b1, 16'd1000, 16'd10);
    applyStimulus(1, 1'b1, 16'd65535, 16'd3);
    applyStimulus(2, 1'b1, 16'd7, 16'd9);
    @(negedge clk);
    checkOutput("rr_grant0", 32'(req_ready), 32'b001);
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("rr_grant1", 32'(req_ready), 32'b010);
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("rr_grant2", 32'(req_ready), 32'b100);
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("rr_inflight3", 32'(in_flight), 32'd3);
    anyHit = 1'b0;
    repeat (LAT - 1) begin
      @(negedge clk);
      anyHit = anyHit | (|req_ready);
    end
    checkOutput("rr_no_regrant", 32'(anyHit), 32'd0);
    @(posedge clk); #1;
    req_valid = '0;
    @(negedge clk);
    checkOutput("rr_resp0", 32'({resp_valid, resp_quotient}), 32'({3'b001, 16'd100}));
    @(negedge clk);
    checkOutput("rr_resp1", 32'({resp_valid, resp_quotient}), 32'({3'b010, 16'd21845}));
    @(negedge clk);
    checkOutput("rr_resp2", 32'({resp_valid, resp_quotient}), 32'({3'b100, 16'd0}));

    // Fairness after wrap: move the pointer to 2, then 0 and 2 both ask.
    runSingle("ptr_to2", 1, 16'd40, 16'd8, 16'd5, 1'b0);
    @(posedge clk); #1;
    applyStimulus(0, 1'b1, 16'd500, 16'd25);
    applyStimulus(2, 1'b1, 16'd9999, 16'd1);
    @(negedge clk);
    checkOutput("wrap_first", 32'(req_ready), 32'b100);
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("wrap_second", 32'(req_ready), 32'b001);
    @(posedge clk); #1;
    req_valid = '0;
    repeat (LAT + 2) @(negedge clk);
    checkOutput("wrap_resp2", 32'({resp_valid, resp_quotient}), 32'({3'b100, 16'd9999}));
    @(negedge clk);
    checkOutput("wrap_resp0", 32'({resp_valid, resp_quotient}), 32'({3'b001, 16'd20}));
    @(negedge clk);
    checkOutput("wrap_inflight0", 32'(in_flight), 32'd0);

    // Back-to-back reuse: re-request during the response pulse.
    @(posedge clk); #1;
    applyStimulus(0, 1'b1, 16'd300, 16'd4);
    @(negedge clk);
    checkOutput("reuse_ready", 32'(req_ready), 32'b001);
    @(posedge clk); #1;
    applyStimulus(0, 1'b0, 16'd300, 16'd4);
    repeat (LAT + 2) @(negedge clk);
    @(posedge clk); #1;
    applyStimulus(0, 1'b1, 16'd81, 16'd9);
    @(negedge clk);
    checkOutput("reuse_resp1", 32'({resp_valid, resp_quotient}), 32'({3'b001, 16'd75}));
    checkOutput("reuse_blocked", 32'(req_ready), 32'b000);
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("reuse_regrant", 32'(req_ready), 32'b001);
    @(posedge clk); #1;
    applyStimulus(0, 1'b0, 16'd81, 16'd9);
    @(negedge clk);
    checkOutput("reuse_dividend2", 32'(div_dividend), 32'd81);
    repeat (LAT + 2) @(negedge clk);
    checkOutput("reuse_resp2", 32'({resp_valid, resp_quotient}), 32'({3'b001, 16'd9}));

    // Reset mid-flight: three operations issued, reset five cycles later.
    @(posedge clk); #1;
    applyStimulus(0, 1'b1, 16'd11, 16'd1);
    applyStimulus(1, 1'b1, 16'd22, 16'd2);
    applyStimulus(2, 1'b1, 16'd33, 16'd3);
    @(negedge clk);
    checkOutput("mid_grant1", 32'(req_ready), 32'b010);
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("mid_grant2", 32'(req_ready), 32'b100);
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("mid_grant0", 32'(req_ready), 32'b001);
    @(posedge clk); #1;
    req_valid = '0;
    @(negedge clk);
    checkOutput("mid_inflight3", 32'(in_flight), 32'd3);
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    checkOutput("mid_async_inflight", 32'(in_flight), 32'd0);
    checkOutput("mid_async_dividend", 32'(div_dividend), 32'd0);
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b0;
    anyHit = 1'b0;
    repeat (LAT + 4) begin
      @(negedge clk);
      anyHit = anyHit | (|resp_valid);
    end
    checkOutput("mid_no_resp", 32'(anyHit), 32'd0);
    checkOutput("mid_inflight0", 32'(in_flight), 32'd0);
    runSingle("after_rst", 2, 16'd1234, 16'd2, 16'd617, 1'b0);

    // Every expected response must have been consumed.
    repeat (3) @(negedge clk);
    checkOutput("sb_drained", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
